// File: rtl/rambam_inv_key_sched.sv
// Reverse-order AES-128 round-key generator: expands forward to round 10, then streams
// round keys 10..0, undoing one expansion step per key through a shared external S-box.
module rambam_inv_key_sched #(
  parameter int unsigned SBOX_LAT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key,
  output logic         busy,
  output logic         sbox_req,
  output logic [0:31]  sbox_in,
  input  logic [0:31]  sbox_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [2:0] {
    StIdle, StFwdReq, StFwdWait, StEmit, StBwdReq, StBwdWait
  } state_e;

  localparam logic [3:0] CtrLoad = 4'(SBOX_LAT - 1);

  state_e       state, state_d;
  logic [0:127] kreg, kreg_d;
  logic [3:0]   rnd, rnd_d;
  logic [7:0]   rcon, rcon_d;
  logic [3:0]   wait_ctr, wait_ctr_d;
  logic         done_q, done_d;

  logic [0:31] k0, k1, k2, k3;
  logic [0:31] t, n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] xinv(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [0:31] rot_word(input logic [0:31] w);
    return {w[8:31], w[0:7]};
  endfunction

  assign k0 = kreg[0:31];
  assign k1 = kreg[32:63];
  assign k2 = kreg[64:95];
  assign k3 = kreg[96:127];

  assign t  = sbox_out ^ {rcon, 24'h0};
  assign n0 = k0 ^ t;
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

  // done_q keeps busy high for the done cycle so a new start waits one more cycle.
  assign busy = (state != StIdle) || done_q;
  assign done = done_q;

  always_comb begin
    state_d    = state;
    kreg_d     = kreg;
    rnd_d      = rnd;
    rcon_d     = rcon;
    wait_ctr_d = wait_ctr;
    done_d     = 1'b0;
    sbox_req   = 1'b0;
    sbox_in    = '0;
    rk_valid   = 1'b0;
    rk         = '0;
    rk_round   = '0;

    unique case (state)
      StIdle: begin
        if (start && !done_q) begin
          kreg_d  = key;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = StFwdReq;
        end
      end
      StFwdReq: begin
        sbox_req   = 1'b1;
        sbox_in    = rot_word(k3);
        wait_ctr_d = CtrLoad;
        state_d    = StFwdWait;
      end
      StFwdWait: begin
        if (wait_ctr == 4'd0) begin
          kreg_d = {n0, n1, n2, n3};
          rnd_d  = rnd + 4'd1;
          // The last forward step keeps rcon at 0x36 for the first backward step.
          if (rnd == 4'd9) begin
            state_d = StEmit;
          end else begin
            rcon_d  = xtime(rcon);
            state_d = StFwdReq;
          end
        end else begin
          wait_ctr_d = wait_ctr - 4'd1;
        end
      end
      StEmit: begin
        rk_valid = 1'b1;
        rk       = kreg;
        rk_round = rnd;
        if (rk_ready) begin
          if (rnd == 4'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            kreg_d  = {k0, k1 ^ k0, k2 ^ k1, k3 ^ k2};
            state_d = StBwdReq;
          end
        end
      end
      StBwdReq: begin
        sbox_req   = 1'b1;
        sbox_in    = rot_word(k3);
        wait_ctr_d = CtrLoad;
        state_d    = StBwdWait;
      end
      StBwdWait: begin
        if (wait_ctr == 4'd0) begin
          kreg_d[0:31] = k0 ^ t;
          rnd_d        = rnd - 4'd1;
          rcon_d       = xinv(rcon);
          state_d      = StEmit;
        end else begin
          wait_ctr_d = wait_ctr - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      kreg     <= '0;
      rnd      <= '0;
      rcon     <= '0;
      wait_ctr <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      kreg     <= kreg_d;
      rnd      <= rnd_d;
      rcon     <= rcon_d;
      wait_ctr <= wait_ctr_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_rambam_inv_key_sched.sv
// Bench for rambam_inv_key_sched: three instances (S-box latency 7, 1, 15) with behavioural
// S-boxes; round keys are checked against a bench-side key expansion through a scoreboard queue.
module tb_rambam_inv_key_sched;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic         start_v    [N];
  logic [0:127] key;
  logic         busy_v     [N];
  logic         sbox_req_v [N];
  logic [0:31]  sbox_in_v  [N];
  logic         rk_valid_v [N];
  logic         rk_ready_v [N];
  logic [0:127] rk_v       [N];
  logic [3:0]   rk_round_v [N];
  logic         done_v     [N];

  localparam logic [0:127] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic logic [7:0] exp_rcon(input int i);
    logic [7:0] rc = 8'h01;
    for (int j = 0; j < i; j++) rc = xt(rc);
    return rc;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 7 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 7 : ((g == 1) ? 1 : 15);
    logic [0:31] sbox_out;
    logic [31:0] dl   [16];
    logic        dl_v [16];

    rambam_inv_key_sched #(.SBOX_LAT(L)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .key      (key),
      .busy     (busy_v[g]),
      .sbox_req (sbox_req_v[g]),
      .sbox_in  (sbox_in_v[g]),
      .sbox_out (sbox_out),
      .rk_valid (rk_valid_v[g]),
      .rk_ready (rk_ready_v[g]),
      .rk       (rk_v[g]),
      .rk_round (rk_round_v[g]),
      .done     (done_v[g])
    );

    // Result of the request made in cycle c is driven for cycle c+L only; junk otherwise.
    always @(negedge clk) begin
      for (int i = 15; i > 0; i--) begin
        dl[i]   = dl[i-1];
        dl_v[i] = dl_v[i-1];
      end
      dl[0]   = sub_word(sbox_in_v[g]);
      dl_v[0] = sbox_req_v[g];
      sbox_out = dl_v[L] ? dl[L] : $urandom();
    end
  end

  typedef struct {
    logic [3:0]   rnd;
    logic [0:127] k;
  } exp_t;
  exp_t exp_q[$];
  logic [0:127] exp_rk [11];

  int           req_cnt     [N] = '{default: 0};
  int           hs_cnt      [N] = '{default: 0};
  int           done_cnt    [N] = '{default: 0};
  int           last_hs     [N] = '{default: 0};
  int           first_valid [N] = '{default: 0};
  logic         seen_valid  [N] = '{default: 1'b0};
  logic         stall_prev  [N] = '{default: 1'b0};
  logic [0:127] prev_rk     [N];
  logic [3:0]   prev_rnd    [N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int r = 10; r >= 0; r--) exp_q.push_back('{rnd: 4'(r), k: exp_rk[r]});
  endtask

  // Monitor: idle-zero outputs, stall stability, handshakes against model and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int g = 0; g < N; g++) stall_prev[g] = 1'b0;
    end else begin
      for (int g = 0; g < N; g++) begin
        if (sbox_req_v[g]) req_cnt[g]++;
        else chk("sbox_in_idle", sbox_in_v[g], 0);
        if (!rk_valid_v[g]) begin
          chk("rk_idle", rk_v[g], 0);
          chk("rk_round_idle", rk_round_v[g], 0);
        end
        if (stall_prev[g]) begin
          chk("stall_valid", rk_valid_v[g], 1);
          chk("stall_rk", rk_v[g], prev_rk[g]);
          chk("stall_round", rk_round_v[g], prev_rnd[g]);
          chk("stall_no_req", sbox_req_v[g], 0);
        end
        if (rk_valid_v[g] && !seen_valid[g]) begin
          seen_valid[g]  = 1'b1;
          first_valid[g] = cyc;
        end
        if (rk_valid_v[g] && rk_ready_v[g]) begin
          hs_cnt[g]++;
          last_hs[g] = cyc;
          if (rk_round_v[g] <= 4'd10) chk("rk_model", rk_v[g], exp_rk[rk_round_v[g]]);
          case (rk_round_v[g])
            4'd10: chk("fips_rk10", rk_v[g], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            4'd9:  chk("fips_rk9", rk_v[g], 128'hac7766f319fadc2128d12941575c006e);
            4'd1:  chk("fips_rk1", rk_v[g], 128'ha0fafe1788542cb123a339392a6c7605);
            4'd0:  chk("fips_rk0", rk_v[g], FipsKey);
            default: ;
          endcase
          if (g == 0) begin
            if (rk_round_v[0] != 4'd0)
              chk("rcon_bwd", g_dut[0].u_dut.rcon, exp_rcon(int'(rk_round_v[0]) - 1));
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("sb_round", rk_round_v[0], e.rnd);
              chk("sb_rk", rk_v[0], e.k);
            end
          end
        end
        if (done_v[g]) done_cnt[g]++;
        stall_prev[g] = rk_valid_v[g] && !rk_ready_v[g];
        prev_rk[g]    = rk_v[g];
        prev_rnd[g]   = rk_round_v[g];
      end
    end
  end

  initial begin
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [3:0]  r;
    int t0, nreq;
    int hs_b [N];
    int req_b [N];
    int done_b [N];

    rst = 1'b1;
    key = '0;
    for (int g = 0; g < N; g++) begin
      start_v[g]    = 1'b0;
      rk_ready_v[g] = 1'b1;
    end

    w[0] = FipsKey[0:31];
    w[1] = FipsKey[32:63];
    w[2] = FipsKey[64:95];
    w[3] = FipsKey[96:127];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

    repeat (3) tick();
    chk("rst_busy", busy_v[0], 0);
    chk("rst_sbox_req", sbox_req_v[0], 0);
    chk("rst_sbox_in", sbox_in_v[0], 0);
    chk("rst_rk_valid", rk_valid_v[0], 0);
    chk("rst_rk", rk_v[0], 0);
    chk("rst_rk_round", rk_round_v[0], 0);
    chk("rst_done", done_v[0], 0);
    rst = 1'b0;
    tick();

    // Run 1: FIPS key on all three latencies, rcon walk, start while busy.
    for (int g = 0; g < N; g++) begin
      hs_b[g] = hs_cnt[g]; req_b[g] = req_cnt[g]; done_b[g] = done_cnt[g];
    end
    key = FipsKey;
    for (int g = 0; g < N; g++) start_v[g] = 1'b1;
    t0 = cyc;
    push_run();
    tick();
    for (int g = 0; g < N; g++) start_v[g] = 1'b0;
    chk("busy_after_start", busy_v[0], 1);
    chk("first_req", sbox_req_v[0], 1);
    key = '0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 200 && g_dut[0].u_dut.rnd != 4'd7; i++) tick();
    chk("rnd7_seen", g_dut[0].u_dut.rnd, 7);
    chk("rcon_fwd_80", g_dut[0].u_dut.rcon, 8'h80);
    for (int i = 0; i < 50 && g_dut[0].u_dut.rnd != 4'd8; i++) tick();
    chk("rnd8_seen", g_dut[0].u_dut.rnd, 8);
    chk("rcon_fwd_1b", g_dut[0].u_dut.rcon, 8'h1b);
    for (int i = 0; i < 50 && g_dut[0].u_dut.rnd != 4'd9; i++) tick();
    chk("rnd9_seen", g_dut[0].u_dut.rnd, 9);
    chk("rcon_fwd_36", g_dut[0].u_dut.rcon, 8'h36);
    for (int i = 0; i < 50 && !rk_valid_v[0]; i++) tick();
    chk("first_valid_cycle", cyc - t0, 81);
    chk("first_round", rk_round_v[0], 10);
    chk("rcon_at_10", g_dut[0].u_dut.rcon, 8'h36);
    for (int i = 0; i < 400 && !done_v[0]; i++) tick();
    chk("done_seen", done_v[0], 1);
    chk("done_cycle", cyc, last_hs[0] + 1);
    chk("busy_with_done", busy_v[0], 1);
    tick();
    chk("busy_after_done", busy_v[0], 0);
    chk("done_one_cycle", done_v[0], 0);
    for (int i = 0; i < 1000 && (busy_v[1] || busy_v[2]); i++) tick();
    chk("lat_runs_done", busy_v[1] | busy_v[2], 0);
    for (int g = 0; g < N; g++) begin
      chk("run1_handshakes", hs_cnt[g] - hs_b[g], 11);
      chk("run1_done_pulses", done_cnt[g] - done_b[g], 1);
      chk("run1_sbox_reqs", req_cnt[g] - req_b[g], 20);
      chk("first_valid_lat", first_valid[g] - t0, 10 * (lat_of(g) + 1) + 1);
    end
    chk("run1_sb_drained", exp_q.size(), 0);

    // Run 2: backpressure of 20 cycles at rounds 10, 5 and 0.
    hs_b[0] = hs_cnt[0]; req_b[0] = req_cnt[0]; done_b[0] = done_cnt[0];
    rk_ready_v[0] = 1'b0;
    key = FipsKey;
    start_v[0] = 1'b1;
    push_run();
    tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < 200 && !rk_valid_v[0]; i++) tick();
      chk("bp_valid", rk_valid_v[0], 1);
      r = rk_round_v[0];
      if (r == 4'd10 || r == 4'd5 || r == 4'd0) repeat (20) tick();
      rk_ready_v[0] = 1'b1;
      tick();
      rk_ready_v[0] = 1'b0;
      chk("bp_valid_drop", rk_valid_v[0], 0);
    end
    chk("bp_done", done_v[0], 1);
    chk("bp_handshakes", hs_cnt[0] - hs_b[0], 11);
    chk("bp_sbox_reqs", req_cnt[0] - req_b[0], 20);
    rk_ready_v[0] = 1'b1;
    tick();

    // Run 3: reset (with start high) right after the 4th request, then a fresh run.
    key = FipsKey;
    start_v[0] = 1'b1;
    push_run();
    tick();
    start_v[0] = 1'b0;
    nreq = sbox_req_v[0] ? 1 : 0;
    for (int i = 0; i < 100 && nreq < 4; i++) begin
      tick();
      if (sbox_req_v[0]) nreq++;
    end
    chk("rr_four_reqs", nreq, 4);
    tick();
    rst = 1'b1;
    start_v[0] = 1'b1;
    exp_q.delete();
    tick();
    chk("rr_busy", busy_v[0], 0);
    chk("rr_sbox_req", sbox_req_v[0], 0);
    chk("rr_sbox_in", sbox_in_v[0], 0);
    chk("rr_rk_valid", rk_valid_v[0], 0);
    chk("rr_rk", rk_v[0], 0);
    chk("rr_rk_round", rk_round_v[0], 0);
    chk("rr_done", done_v[0], 0);
    rst = 1'b0;
    hs_b[0] = hs_cnt[0]; done_b[0] = done_cnt[0];
    t0 = cyc;
    push_run();
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 200 && !rk_valid_v[0]; i++) tick();
    chk("rr_first_valid_cycle", cyc - t0, 81);
    for (int i = 0; i < 400 && !done_v[0]; i++) tick();
    chk("rr_done_seen", done_v[0], 1);
    tick();
    chk("rr_handshakes", hs_cnt[0] - hs_b[0], 11);
    chk("rr_done_pulses", done_cnt[0] - done_b[0], 1);
    chk("rr_sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rambam_inv_key_sched.md
# rambam_inv_key_sched

Reverse-order AES-128 round-key generator for the RAMBAM decryption datapath: the inverse-cipher counterpart of the encryption core's forward key schedule. It accepts the 128-bit cipher key and runs the forward expansion to round 10. It then streams round keys 10, 9, …, 0 to the inverse-round datapath over a valid/ready handshake, recomputing each earlier key from the current one. All SubWord operations use one external, shared, fixed-latency S-box port, the same single-S-box arrangement the encryption core uses.

## Interface
- `SBOX_LAT`, 7: cycles from an `sbox_req` to valid `sbox_out`; legal range 1–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a schedule. Sampled only when `busy`=0.
- `key` in [0:127]: cipher key, captured on accepted `start`. Bit 0 is the MSB of byte 0. Word w0 = `key[0:31]`.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after the final handshake.
- `sbox_req` out 1: one-cycle request strobe.
- `sbox_in` out [0:31]: RotWord of the current word 3; valid only while `sbox_req`=1, otherwise 0.
- `sbox_out` in [0:31]: bytewise S-box result, valid exactly `SBOX_LAT` cycles after `sbox_req`.
- `rk_valid` out 1: round key presented.
- `rk_ready` in 1: consumer accepts the key.
- `rk` out [0:127]: current round key. 0 when `rk_valid`=0.
- `rk_round` out [3:0]: index of `rk`, 10 down to 0. 0 when `rk_valid`=0.
- `done` out 1: one-cycle pulse after round key 0 is accepted.

## Operation
- States: IDLE, FWD_REQ, FWD_WAIT, EMIT, BWD_REQ, BWD_WAIT.
- Registers:
  - `kreg` [0:127]: current round key.
  - `rnd` [3:0]: round index.
  - `rcon` [7:0]: round constant.
  - `wait_ctr`: sized for `SBOX_LAT`.
- **IDLE**: on `start`, `kreg`←`key`, `rnd`←0, `rcon`←0x01, go to FWD_REQ.
- **FWD_REQ** (one cycle):
  - `sbox_req`=1, `sbox_in`=RotWord(k3), where RotWord rotates left by one byte.
  - Load `wait_ctr`, go to FWD_WAIT.
- **FWD_WAIT**: count down. In the cycle `sbox_out` is valid:
  - t = `sbox_out` ^ {`rcon`,24'h0}.
  - n0 = k0^t, n1 = k1^n0, n2 = k2^n1, n3 = k3^n2.
  - `kreg`←{n0,n1,n2,n3}, `rnd`←`rnd`+1, `rcon`←xtime(`rcon`).
  - If new `rnd`=10, go to EMIT, keeping `rcon` at 0x36 (xtime skipped on the last step). Otherwise go to FWD_REQ.
- xtime(b): (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits.
- **EMIT**: `rk_valid`=1, `rk`=`kreg`, `rk_round`=`rnd`. On `rk_valid`&`rk_ready`:
  - If `rnd`=0: go to IDLE and pulse `done`.
  - Otherwise: go to BWD_REQ with p3 = k3^k2 latched into `kreg` word 3 along with the other prior words. That is, `kreg`←{k0, k1^k0, k2^k1, k3^k2}.
- **BWD_REQ**: `sbox_req`=1, `sbox_in`=RotWord(word 3 of `kreg`), go to BWD_WAIT.
- **BWD_WAIT**: in the valid cycle:
  - word 0 ← word 0 ^ `sbox_out` ^ {`rcon`,24'h0}.
  - `rnd`←`rnd`−1, `rcon`←xinv(`rcon`), go to EMIT.
- xinv(b): b[0] ? ((b^0x1B)>>1)|0x80 : b>>1. It takes 0x1B→0x80 and 0x01→0x8D; the 0x8D value is never used.
- `rcon` therefore steps forward 01,02,…,80,1B,36 and back 36,1B,80,…,01.
- `start` while `busy`=1 is ignored and does not corrupt `kreg`.
- At most one S-box request is outstanding at any time. `sbox_out` is ignored outside the expected cycle.

## Timing
- Reset, and the value whenever a signal is not active, is 0 for every output: `busy`, `sbox_req`, `sbox_in`, `rk_valid`, `rk`, `rk_round`, `done`.
- `rst` in any state returns the block to IDLE on the next edge and clears all registers. An S-box result still in flight is discarded.
- Forward phase: `start` accepted in cycle 0. Request k is issued in cycle 1+(k−1)(`SBOX_LAT`+1), for k = 1…10.
- First `rk_valid` (round 10) in cycle 10(`SBOX_LAT`+1)+1, which is cycle 81 at the default `SBOX_LAT`.
- After a handshake in cycle h (`rnd`>0), `sbox_req` is in cycle h+1 and the next `rk_valid` is in cycle h+`SBOX_LAT`+2.
- `rk_valid` drops in the cycle after each handshake.
- If `rk_ready` is held low, `rk_valid`, `rk` and `rk_round` stay stable indefinitely. A handshake in the first valid cycle is legal.
- After the round-0 handshake in cycle h: `done`=1 and `busy`=1 in cycle h+1; `busy`=0 in cycle h+2. A new `start` is accepted from cycle h+2.

## Test plan
- **FIPS-197 key**: `key`=2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1 and a behavioural S-box with latency 7. Required:
  - First output `rk_round`=10, `rk`=d014f9a8c9ee2589e13f0cc8b6630ca6, in cycle 81.
  - `rk_round`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `rk_round`=0 gives the input key.
  - Exactly 11 handshakes followed by one `done` pulse.
- **Backpressure**: hold `rk_ready`=0 for 20 cycles at rounds 10, 5 and 0. Required: outputs stable, no `sbox_req` during the stall, same key sequence as the FIPS-197 test.
- **Latency sweep**: `SBOX_LAT`=1 and `SBOX_LAT`=15. Required: identical keys, first `rk_valid` in cycles 21 and 161, and exactly 20 `sbox_req` pulses per run.
- **Rcon wrap**: check internal `rcon` goes 0x80→0x1B→0x36 forward and 0x36→0x1B→0x80 backward. Required: round-9 key ac7766f319fadc2128d12941575c006e.
- **Reset mid-run**: assert `rst` in the cycle after the 4th `sbox_req`, with `start` also high. Required: all outputs 0 the next cycle, a late `sbox_out` is ignored, and a fresh `start` reproduces the FIPS-197 results.
- **Start while busy**: pulse `start` with `key`=0 during the forward phase. Required: ignored; output keys match the first key.
